// File: rtl/grid_pkg.sv
// Shared matrix geometry, index widths and heading encodings for the grid stepper.
package grid_pkg;

   localparam int unsigned GRID_W  = 80;
   localparam int unsigned GRID_H  = 50;
   localparam int unsigned IDX_X_W = 7;
   localparam int unsigned IDX_Y_W = 6;
   localparam int unsigned DIR_W   = 2;

   localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd1;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd2;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd3;

   // Opposite heading: the encoding puts opposites two apart, so flip bit 1.
   function automatic logic [DIR_W-1:0] reverse_dir(input logic [DIR_W-1:0] d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/grid_step_controller_if.sv
// Valid/ready channel carrying heading requests into the grid stepper.
interface grid_step_controller_if;
   import grid_pkg::*;

   logic [DIR_W-1:0] dir_req;
   logic             dir_valid;
   logic             dir_ready;

   modport master (output dir_req, output dir_valid, input dir_ready);
   modport slave  (input dir_req, input dir_valid, output dir_ready);

endinterface

// File: rtl/grid_step_controller_step_timer.sv
// Free-running step period counter; tick marks the last cycle of each enabled period.
module step_timer #(
   parameter int unsigned STEP_TICKS = 8_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int unsigned   CNT_W = $clog2(STEP_TICKS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

   logic [CNT_W-1:0] cnt;

   always_comb begin
      tick = enable && (cnt == LAST);
   end

   // Counter holds while paused so a pause of N cycles delays the step by N.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/grid_step_controller.sv
// Owns the object position on the play matrix and advances it one cell per step,
// applying at most one buffered heading change per step and dropping reversals.
module grid_step_controller
   import grid_pkg::*;
#(
   parameter int unsigned      STEP_TICKS = 8_000_000,
   parameter int unsigned      START_X    = 40,
   parameter int unsigned      START_Y    = 25,
   parameter logic [DIR_W-1:0] START_DIR  = DIR_RIGHT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   grid_step_controller_if.slave   dir,
   output logic [IDX_X_W-1:0]      matrix_idx_x,
   output logic [IDX_Y_W-1:0]      matrix_idx_y,
   output logic [DIR_W-1:0]        heading,
   output logic                    step_pulse
);

   localparam logic [IDX_X_W-1:0] X_MAX = IDX_X_W'(GRID_W - 1);
   localparam logic [IDX_Y_W-1:0] Y_MAX = IDX_Y_W'(GRID_H - 1);

   logic                tick;
   logic                buf_empty;
   logic [DIR_W-1:0]    pend_dir;
   logic [DIR_W-1:0]    eff_dir;
   logic [IDX_X_W-1:0]  next_x;
   logic [IDX_Y_W-1:0]  next_y;
   logic                accept;

   step_timer #(.STEP_TICKS(STEP_TICKS)) u_step_timer (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (tick)
   );

   assign dir.dir_ready = buf_empty;
   assign accept        = dir.dir_valid && buf_empty;

   // Heading for the coming step and the wrapped neighbour cell in that heading.
   always_comb begin
      eff_dir = heading;
      next_x  = matrix_idx_x;
      next_y  = matrix_idx_y;
      if (!buf_empty && (pend_dir != reverse_dir(heading))) begin
         eff_dir = pend_dir;
      end
      case (eff_dir)
         DIR_UP:    next_y = (matrix_idx_y == '0)    ? Y_MAX : matrix_idx_y - IDX_Y_W'(1);
         DIR_DOWN:  next_y = (matrix_idx_y == Y_MAX) ? '0    : matrix_idx_y + IDX_Y_W'(1);
         DIR_LEFT:  next_x = (matrix_idx_x == '0)    ? X_MAX : matrix_idx_x - IDX_X_W'(1);
         default:   next_x = (matrix_idx_x == X_MAX) ? '0    : matrix_idx_x + IDX_X_W'(1);
      endcase
   end

   // Acceptance only happens with an empty buffer, so it never collides with a drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         matrix_idx_x <= IDX_X_W'(START_X);
         matrix_idx_y <= IDX_Y_W'(START_Y);
         heading      <= START_DIR;
         step_pulse   <= 1'b0;
         buf_empty    <= 1'b1;
         pend_dir     <= DIR_UP;
      end else begin
         step_pulse <= tick;
         if (tick) begin
            heading      <= eff_dir;
            matrix_idx_x <= next_x;
            matrix_idx_y <= next_y;
            buf_empty    <= 1'b1;
         end
         if (accept) begin
            pend_dir  <= dir.dir_req;
            buf_empty <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_grid_step_controller.sv
// Directed bench for grid_step_controller with a 4-cycle step period.
module tb_grid_step_controller;

   localparam int unsigned TICKS = 4;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [6:0] x;
   logic [5:0] y;
   logic [1:0] hdg;
   logic       pulse;

   int total;
   int bad;

   grid_step_controller_if dir_bus ();

   grid_step_controller #(
      .STEP_TICKS (TICKS),
      .START_X    (40),
      .START_Y    (25),
      .START_DIR  (2'd1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .dir          (dir_bus.slave),
      .matrix_idx_x (x),
      .matrix_idx_y (y),
      .heading      (hdg),
      .step_pulse   (pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Leaves the bench at the negedge of cycle 0 after reset release.
   task automatic do_reset();
      @(negedge clk);
      rst               = 1'b1;
      enable            = 1'b1;
      dir_bus.dir_valid = 1'b0;
      dir_bus.dir_req   = 2'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_pulse(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pulse) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Presented right after a pulse so acceptance lands on a non-step edge.
   task automatic send_dir(input logic [1:0] d);
      dir_bus.dir_req   = d;
      dir_bus.dir_valid = 1'b1;
      @(negedge clk);
      dir_bus.dir_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({x, y, hdg, dir_bus.dir_ready, pulse} !== {7'd40, 6'd25, 2'd1, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_state got x=%0d y=%0d h=%0d rdy=%0b p=%0b want 40 25 1 1 0",
                  x, y, hdg, dir_bus.dir_ready, pulse);
      end
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         total++;
         if (pulse !== (k % 4 == 0)) begin
            bad++;
            $display("FAIL pulse_cadence cycle %0d got %0b want %0b", k, pulse, (k % 4 == 0));
         end
         if (k % 4 == 0) begin
            total++;
            if ({x, y} !== {7'(40 + k / 4), 6'd25}) begin
               bad++;
               $display("FAIL first_steps cycle %0d got x=%0d y=%0d want x=%0d y=25",
                        k, x, y, 40 + k / 4);
            end
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      do_reset();
      for (int s = 0; s < 39; s++) wait_pulse(ok);
      total++;
      if (!ok || x !== 7'd79) begin
         bad++;
         $display("FAIL reach_right_edge got x=%0d ok=%0b want 79", x, ok);
      end
      wait_pulse(ok);
      total++;
      if (!ok || x !== 7'd0) begin
         bad++;
         $display("FAIL right_wrap got x=%0d ok=%0b want 0", x, ok);
      end
      send_dir(2'd0);
      wait_pulse(ok);
      total++;
      if (!ok || {x, y, hdg} !== {7'd0, 6'd24, 2'd0}) begin
         bad++;
         $display("FAIL turn_up got x=%0d y=%0d h=%0d want 0 24 0", x, y, hdg);
      end
      for (int s = 0; s < 24; s++) wait_pulse(ok);
      total++;
      if (!ok || y !== 6'd0) begin
         bad++;
         $display("FAIL reach_top got y=%0d ok=%0b want 0", y, ok);
      end
      wait_pulse(ok);
      total++;
      if (!ok || {x, y} !== {7'd0, 6'd49}) begin
         bad++;
         $display("FAIL top_wrap got x=%0d y=%0d want 0 49", x, y);
      end
   endtask

   task automatic test_reversal();
      bit ok;
      do_reset();
      wait_pulse(ok);
      send_dir(2'd3);
      total++;
      if (dir_bus.dir_ready !== 1'b0) begin
         bad++;
         $display("FAIL reversal_accept got rdy=%0b want 0", dir_bus.dir_ready);
      end
      wait_pulse(ok);
      total++;
      if (!ok || {x, y, hdg, dir_bus.dir_ready} !== {7'd42, 6'd25, 2'd1, 1'b1}) begin
         bad++;
         $display("FAIL reversal_drop got x=%0d y=%0d h=%0d rdy=%0b want 42 25 1 1",
                  x, y, hdg, dir_bus.dir_ready);
      end
   endtask

   task automatic test_buffer_full();
      bit ok;
      do_reset();
      wait_pulse(ok);
      send_dir(2'd2);
      dir_bus.dir_req   = 2'd0;
      dir_bus.dir_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      dir_bus.dir_valid = 1'b0;
      total++;
      if (dir_bus.dir_ready !== 1'b0) begin
         bad++;
         $display("FAIL buffer_held got rdy=%0b want 0", dir_bus.dir_ready);
      end
      wait_pulse(ok);
      total++;
      if (!ok || {x, y, hdg, dir_bus.dir_ready} !== {7'd41, 6'd26, 2'd2, 1'b1}) begin
         bad++;
         $display("FAIL buffer_down got x=%0d y=%0d h=%0d rdy=%0b want 41 26 2 1",
                  x, y, hdg, dir_bus.dir_ready);
      end
      wait_pulse(ok);
      total++;
      if (!ok || {x, y, hdg} !== {7'd41, 6'd27, 2'd2}) begin
         bad++;
         $display("FAIL ignored_up got x=%0d y=%0d h=%0d want 41 27 2", x, y, hdg);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      do_reset();
      wait_pulse(ok);
      repeat (3) @(negedge clk);
      send_dir(2'd2);
      total++;
      if ({pulse, x, y, hdg, dir_bus.dir_ready} !== {1'b1, 7'd42, 6'd25, 2'd1, 1'b0}) begin
         bad++;
         $display("FAIL simul_step got p=%0b x=%0d y=%0d h=%0d rdy=%0b want 1 42 25 1 0",
                  pulse, x, y, hdg, dir_bus.dir_ready);
      end
      wait_pulse(ok);
      total++;
      if (!ok || {x, y, hdg} !== {7'd42, 6'd26, 2'd2}) begin
         bad++;
         $display("FAIL simul_next got x=%0d y=%0d h=%0d want 42 26 2", x, y, hdg);
      end
   endtask

   task automatic test_pause_reset();
      bit ok;
      do_reset();
      wait_pulse(ok);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         total++;
         if (pulse !== (k == 14) || x !== ((k == 14) ? 7'd42 : 7'd41)) begin
            bad++;
            $display("FAIL pause cycle %0d got p=%0b x=%0d want p=%0b x=%0d",
                     k, pulse, x, (k == 14), (k == 14) ? 42 : 41);
         end
         if (k == 1)  enable = 1'b0;
         if (k == 11) enable = 1'b1;
      end
      send_dir(2'd2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({x, y, hdg, dir_bus.dir_ready, pulse} !== {7'd40, 6'd25, 2'd1, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL midrun_reset got x=%0d y=%0d h=%0d rdy=%0b p=%0b want 40 25 1 1 0",
                  x, y, hdg, dir_bus.dir_ready, pulse);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         total++;
         if (pulse !== (k == 4)) begin
            bad++;
            $display("FAIL restart_cadence cycle %0d got %0b want %0b", k, pulse, (k == 4));
         end
      end
      total++;
      if ({x, y, hdg} !== {7'd41, 6'd25, 2'd1}) begin
         bad++;
         $display("FAIL pending_lost got x=%0d y=%0d h=%0d want 41 25 1", x, y, hdg);
      end
   endtask

   initial begin
      total             = 0;
      bad               = 0;
      rst               = 1'b1;
      enable            = 1'b1;
      dir_bus.dir_valid = 1'b0;
      dir_bus.dir_req   = 2'd0;
      test_reset();
      test_wrap();
      test_reversal();
      test_buffer_full();
      test_simultaneous();
      test_pause_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
